// File: rtl/noc_request_axilite.sv
// noc_request_axilite: AXI-Lite slave that turns single-beat reads/writes into
// OpenPiton non-cacheable NoC1 request packets and queues response descriptors.
module noc_request_axilite #(
  parameter int AXILITE_ADDR_WIDTH = 64,
  parameter int AXILITE_DATA_WIDTH = 64,
  parameter int NOC_DATA_WIDTH = 64,
  parameter logic [7:0] MSG_TYPE_NC_LOAD_REQ = 8'd14,
  parameter logic [7:0] MSG_TYPE_NC_STORE_REQ = 8'd15
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXILITE_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [7:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [13:0]                   src_chipid,
  input  logic [7:0]                    src_x,
  input  logic [7:0]                    src_y,
  input  logic [13:0]                   dst_chipid,
  input  logic [7:0]                    dst_x,
  input  logic [7:0]                    dst_y,
  output logic                          noc_valid_out,
  output logic [NOC_DATA_WIDTH-1:0]     noc_data_out,
  input  logic                          noc_ready_in,
  output logic [5:0]                    transaction_type_wr_data,
  output logic                          transaction_type_wr,
  input  logic                          type_fifo_full,
  output logic                          err_strb
);
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, DATA} state_t;
  state_t state, state_nx;
  logic rr_rd, rr_rd_nx;
  logic is_wr;
  logic [47:0] addr;
  logic [2:0] size;
  logic [63:0] data;
  logic [5:0] desc;
  logic wr_pend, rd_pend, idle_ok, grant_rd, grant_wr, go;
  logic [2:0] lo, st_size;
  logic strb_ok;
  logic [63:0] swap, hdr0, hdr1, hdr2;
  logic unused;
  assign unused = ^{s_axi_awaddr[AXILITE_ADDR_WIDTH-1:48], s_axi_awaddr[2:0],
                    s_axi_araddr[AXILITE_ADDR_WIDTH-1:48], s_axi_araddr[2:0]};
  always_comb begin
    lo = 3'd0;
    for (int i = 7; i >= 0; i--) if (s_axi_wstrb[i]) lo = 3'(i);
  end
  // Only naturally aligned power-of-two strobe groups map to a NoC size
  always_comb begin
    st_size = 3'b100;
    strb_ok = 1'b1;
    case (s_axi_wstrb)
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80: st_size = 3'b001;
      8'h03, 8'h0C, 8'h30, 8'hC0: st_size = 3'b010;
      8'h0F, 8'hF0: st_size = 3'b011;
      8'hFF: st_size = 3'b100;
      default: strb_ok = 1'b0;
    endcase
  end
  always_comb begin
    swap = '0;
    for (int i = 0; i < 8; i++) swap[63-8*i -: 8] = s_axi_wdata[8*i +: 8];
  end
  assign wr_pend = s_axi_awvalid && s_axi_wvalid;
  assign rd_pend = s_axi_arvalid;
  assign idle_ok = (state == IDLE) && !type_fifo_full;
  assign grant_rd = idle_ok && rd_pend && (!wr_pend || rr_rd);
  assign grant_wr = idle_ok && wr_pend && !grant_rd;
  assign s_axi_arready = grant_rd;
  assign s_axi_awready = grant_wr;
  assign s_axi_wready = grant_wr;
  assign err_strb = grant_wr && !strb_ok;
  assign noc_valid_out = state != IDLE;
  assign go = noc_valid_out && noc_ready_in;
  assign transaction_type_wr_data = desc;
  assign hdr0 = {dst_chipid, dst_x, dst_y, 4'b0, is_wr ? 8'd3 : 8'd2,
                 is_wr ? MSG_TYPE_NC_STORE_REQ : MSG_TYPE_NC_LOAD_REQ, 14'b0};
  assign hdr1 = {addr, size, 13'b0};
  assign hdr2 = {src_chipid, src_x, src_y, 34'b0};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_rd <= 1'b1;
    end else begin
      state <= state_nx;
      rr_rd <= rr_rd_nx;
    end
  end
  always_comb begin
    state_nx = state;
    rr_rd_nx = rr_rd;
    noc_data_out = '0;
    transaction_type_wr = 1'b0;
    case (state)
      IDLE: begin
        state_nx = (grant_rd || (grant_wr && |s_axi_wstrb)) ? HDR0 : IDLE;
        rr_rd_nx = (wr_pend && rd_pend && (grant_rd || grant_wr)) ? !rr_rd : rr_rd;
      end
      HDR0: begin
        noc_data_out = hdr0;
        transaction_type_wr = go;
        state_nx = go ? HDR1 : HDR0;
      end
      HDR1: begin
        noc_data_out = hdr1;
        state_nx = go ? HDR2 : HDR1;
      end
      HDR2: begin
        noc_data_out = hdr2;
        state_nx = go ? (is_wr ? DATA : IDLE) : HDR2;
      end
      DATA: begin
        noc_data_out = data;
        state_nx = go ? IDLE : DATA;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_wr <= 1'b0;
      addr <= '0;
      size <= '0;
      data <= '0;
      desc <= '0;
    end else if (grant_rd) begin
      is_wr <= 1'b0;
      addr <= {s_axi_araddr[47:3], 3'b000};
      size <= 3'b100;
      desc <= {3'b010, s_axi_araddr[3], 2'b01};
    end else if (grant_wr) begin
      is_wr <= 1'b1;
      addr <= {s_axi_awaddr[47:3], strb_ok ? lo : 3'b000};
      size <= st_size;
      data <= swap;
      desc <= 6'b100010;
    end
  end
endmodule
